// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns a valid/ready command stream into pipelined single
// AHB-Lite transfers and reports each completion on a one-cycle response strobe.
// Optional build macro AHB_CMD_MASTER_TIMEOUT_EN: abort a data phase that has
// been stalled by HREADY for TIMEOUT consecutive cycles.
`timescale 1ns/1ps
module ahb_cmd_master #(
  parameter int AWIDTH  = 10,
  parameter int TIMEOUT = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [2:0]        cmd_size,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0]  TRANS_IDLE   = 2'b00;
  localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
  localparam logic [31:0] ABORT_RDATA  = 32'hDEADBEEF;

  // Address-phase slot: the command currently presented (or waiting to be
  // re-presented after an error) on HADDR/HTRANS.
  logic              ap_valid_reg;
  logic [AWIDTH-1:0] ap_addr_reg;
  logic              ap_write_reg;
  logic [2:0]        ap_size_reg;
  logic [31:0]       ap_wdata_reg;

  // Data-phase slot: the transfer whose HWDATA/HRDATA/HRESP is on the bus.
  logic              dp_valid_reg;
  logic              dp_write_reg;
  logic [31:0]       dp_wdata_reg;

  // Set between the two cycles of an ERROR response; parks the address slot.
  logic              err_hold_reg;

  // Command pre-processing (size clamp, address alignment, lane replication).
  logic [2:0]        size_norm;
  logic [AWIDTH-1:0] addr_aligned;
  logic [31:0]       wdata_lanes;

  // Handshake / pipeline advance terms.
  logic ap_on_bus;
  logic ap_done;
  logic dp_done;
  logic accept;
  logic abort_now;

  // Clamp reserved sizes to word and clear the address bits below the size.
  always_comb begin
    size_norm    = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
    addr_aligned = cmd_addr;
    case (size_norm)
      3'd0:    addr_aligned = cmd_addr;
      3'd1:    addr_aligned[0] = 1'b0;
      default: addr_aligned[1:0] = 2'b00;
    endcase
  end

  // Replicate narrow write data onto every byte lane so the slave can pick
  // the active lane from HADDR without the master shifting data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_lanes[gi*8 +: 8] =
        (size_norm == 3'd0) ? cmd_wdata[7:0] :
        (size_norm == 3'd1) ? cmd_wdata[(gi % 2)*8 +: 8] :
                              cmd_wdata[gi*8 +: 8];
  end

  // The address slot is only on the bus while no error response is pending.
  assign ap_on_bus = ap_valid_reg && !err_hold_reg;
  assign ap_done   = ap_on_bus && HREADY;
  assign dp_done   = dp_valid_reg && HREADY;
  assign cmd_ready = !HRESET && (!ap_valid_reg || HREADY) && !err_hold_reg && !abort_now;
  assign accept    = cmd_valid && cmd_ready;

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_reg;

  // Fires on the cycle that would be the TIMEOUT-th consecutive stall.
  assign abort_now = dp_valid_reg && !HREADY && (wait_cnt_reg == CNT_LAST);

  // Count consecutive data-phase stall cycles; any progress restarts it.
  always_ff @(posedge HCLK) begin
    if (HRESET || !dp_valid_reg || HREADY || abort_now) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  assign abort_now = 1'b0;
`endif

  // Address slot: load on accept, free once the slave takes the address.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_valid_reg <= 1'b0;
      ap_addr_reg  <= '0;
      ap_write_reg <= 1'b0;
      ap_size_reg  <= 3'd0;
      ap_wdata_reg <= '0;
    end else if (accept) begin
      ap_valid_reg <= 1'b1;
      ap_addr_reg  <= addr_aligned;
      ap_write_reg <= cmd_write;
      ap_size_reg  <= size_norm;
      ap_wdata_reg <= wdata_lanes;
    end else if (ap_done || abort_now) begin
      ap_valid_reg <= 1'b0;
    end
  end

  // Data slot: filled from the address slot, freed when HREADY ends the phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_wdata_reg <= '0;
    end else if (abort_now) begin
      dp_valid_reg <= 1'b0;
    end else if (ap_done) begin
      dp_valid_reg <= 1'b1;
      dp_write_reg <= ap_write_reg;
      dp_wdata_reg <= ap_wdata_reg;
    end else if (dp_done) begin
      dp_valid_reg <= 1'b0;
    end
  end

  // Error hold: entered on the first ERROR cycle, left when the response ends.
  always_ff @(posedge HCLK) begin
    if (HRESET || abort_now) begin
      err_hold_reg <= 1'b0;
    end else if (dp_valid_reg && HREADY) begin
      err_hold_reg <= 1'b0;
    end else if (dp_valid_reg && HRESP) begin
      err_hold_reg <= 1'b1;
    end
  end

  // Response strobe: one cycle after each completed (or aborted) data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (abort_now) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= ABORT_RDATA;
      rsp_err   <= 1'b1;
    end else if (dp_done) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= dp_write_reg ? 32'd0 : HRDATA;
      rsp_err   <= HRESP;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  assign HTRANS    = ap_on_bus ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = ap_addr_reg;
  assign HWRITE    = ap_write_reg;
  assign HSIZE     = ap_size_reg;
  assign HWDATA    = dp_wdata_reg;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign busy      = ap_valid_reg || dp_valid_reg || err_hold_reg;

endmodule
